// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the pipeline memory-port logic.
package cpu_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter timing the fixed memory read latency.
// Latency: last is a registered decode, high while the count equals 1.
// Backpressure: none; load takes priority over dec, dec stops at zero.
module mem_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = $clog2(MEM_LAT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(MEM_LAT);
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the fetch (IF) and data (MEM) stages.
// Latency: request seen in IDLE cycle t is acked in cycle t+MEM_LAT+2.
// Backpressure: requesters hold req until ack; if_stall/mem_stall freeze the pipeline meanwhile.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_adr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              mem_stall
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic              we_q;
    logic [SW-1:0]     starve_q;
    logic [ADDR_W-1:0] mem_adr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              grant;
    logic              pick_dm;
    logic              starved;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_last;
    logic              capture;

    mem_lat_timer #(
        .MEM_LAT(MEM_LAT)
    ) u_lat_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .last (tmr_last)
    );

    // Data normally wins a tie; fetch wins once data has been granted STARVE_MAX times in a row.
    assign starved = (starve_q == SW'(STARVE_MAX));
    assign pick_dm = dm_req && (!if_req || !starved);
    assign grant   = (state_q == ST_IDLE) && (if_req || dm_req);
    assign capture = (state_q == ST_WAIT) && tmr_last && !we_q;

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            starve_q    <= '0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant) begin
                owner_q   <= pick_dm ? OWN_DM : OWN_IF;
                mem_adr_q <= pick_dm ? dm_adr : if_adr;
                we_q      <= pick_dm && dm_we;
                if (pick_dm) begin
                    mem_wdata_q <= dm_wdata;
                end
                if (pick_dm && if_req) begin
                    if (!starved) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end else begin
                    starve_q <= '0;
                end
            end
            if (capture && (owner_q == OWN_IF)) begin
                if_rdata_q <= mem_rdata;
            end
            if (capture && (owner_q == OWN_DM)) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign dm_ack    = (state_q == ST_DONE) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req && !if_ack;
    assign mem_stall = dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a runs MEM_LAT=2, instance b runs MEM_LAT=1, shared operands.
module tb_mem_port_arbiter;

    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_adr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_adr;
        logic [31:0] dm_wdata;
        int          a_if_cyc;
        int          a_dm_cyc;
        int          b_if_cyc;
        int          b_dm_cyc;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
        int          n_grant;
        logic [31:0] adr0;
        logic        we0;
        logic [31:0] adr1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_adr = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_adr = '0;
    logic [31:0] dm_wdata = '0;

    logic        a_if_req = 1'b0, a_dm_req = 1'b0, b_if_req = 1'b0, b_dm_req = 1'b0;
    logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_if_stall, a_mem_stall;
    logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_if_stall, b_mem_stall;
    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_adr, a_mem_wdata, a_mem_rdata = GARBAGE;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_adr, b_mem_wdata, b_mem_rdata = GARBAGE;

    int checks = 0;
    int errors = 0;
    int cnt_a = 0;
    int cnt_b = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_adr(if_adr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
        .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .if_stall(a_if_stall), .mem_stall(a_mem_stall)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_adr(if_adr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .if_stall(b_if_stall), .mem_stall(b_mem_stall)
    );

    function automatic logic [31:0] mem_img(input logic [31:0] adr);
        case (adr)
            32'h40:  mem_img = 32'h2010_0005;
            32'h44:  mem_img = 32'h00A0_0093;
            32'h200: mem_img = 32'h1234_5678;
            default: mem_img = 32'h0F0F_0F0F;
        endcase
    endfunction

    // Memory models: data is presented only in the cycle exactly MEM_LAT after the strobe.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            cnt_a = 0;
            cnt_b = 0;
            a_mem_rdata = GARBAGE;
            b_mem_rdata = GARBAGE;
        end else begin
            a_mem_rdata = (cnt_a == 1) ? mem_img(a_mem_adr) : GARBAGE;
            b_mem_rdata = (cnt_b == 1) ? mem_img(b_mem_adr) : GARBAGE;
            if (cnt_a != 0) cnt_a--;
            if (cnt_b != 0) cnt_b--;
            if (a_mem_en) cnt_a = 2;
            if (b_mem_en) cnt_b = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a_acks"}, {30'd0, a_if_ack, a_dm_ack}, 32'd0);
        chk({tag, " b_acks"}, {30'd0, b_if_ack, b_dm_ack}, 32'd0);
        chk({tag, " a_en_we"}, {30'd0, a_mem_en, a_mem_we}, 32'd0);
        chk({tag, " b_en_we"}, {30'd0, b_mem_en, b_mem_we}, 32'd0);
        chk({tag, " a_mem_adr"}, a_mem_adr, 32'd0);
        chk({tag, " a_mem_wdata"}, a_mem_wdata, 32'd0);
        chk({tag, " a_if_rdata"}, a_if_rdata, 32'd0);
        chk({tag, " a_dm_rdata"}, a_dm_rdata, 32'd0);
        chk({tag, " b_if_rdata"}, b_if_rdata, 32'd0);
        chk({tag, " b_dm_rdata"}, b_dm_rdata, 32'd0);
    endtask

    // Cycle 0 is the current cycle; each requester drops its req the cycle after its own ack.
    task automatic run_vec(input string tag, input vec_t v);
        int a_if_c = -1, a_dm_c = -1, b_if_c = -1, b_dm_c = -1;
        int a_if_n = 0, a_dm_n = 0, b_if_n = 0, b_dm_n = 0;
        int a_en_n = 0, b_en_n = 0, a_en_c0 = -1, b_en_c0 = -1;
        logic [31:0] a_adr[2];
        logic [31:0] b_adr[2];
        logic [31:0] a_wd0 = '0;
        logic        a_we0 = 1'b0;
        logic        b_we0 = 1'b0;
        if_adr   = v.if_adr;
        dm_we    = v.dm_we;
        dm_adr   = v.dm_adr;
        dm_wdata = v.dm_wdata;
        a_if_req = v.if_req;
        b_if_req = v.if_req;
        a_dm_req = v.dm_req;
        b_dm_req = v.dm_req;
        a_adr[0] = '0; a_adr[1] = '0; b_adr[0] = '0; b_adr[1] = '0;
        for (int c = 0; c < 16; c++) begin
            sample_point();
            chk({tag, " a_if_stall"}, a_if_stall, a_if_req && (c != v.a_if_cyc));
            chk({tag, " a_mem_stall"}, a_mem_stall, a_dm_req && (c != v.a_dm_cyc));
            chk({tag, " b_if_stall"}, b_if_stall, b_if_req && (c != v.b_if_cyc));
            chk({tag, " b_mem_stall"}, b_mem_stall, b_dm_req && (c != v.b_dm_cyc));
            if (a_if_ack) begin a_if_n++; a_if_c = c; end
            if (a_dm_ack) begin a_dm_n++; a_dm_c = c; end
            if (b_if_ack) begin b_if_n++; b_if_c = c; end
            if (b_dm_ack) begin b_dm_n++; b_dm_c = c; end
            if (a_mem_en) begin
                if (a_en_n == 0) begin a_en_c0 = c; a_we0 = a_mem_we; a_wd0 = a_mem_wdata; end
                if (a_en_n < 2) a_adr[a_en_n] = a_mem_adr;
                a_en_n++;
            end
            if (b_mem_en) begin
                if (b_en_n == 0) begin b_en_c0 = c; b_we0 = b_mem_we; end
                if (b_en_n < 2) b_adr[b_en_n] = b_mem_adr;
                b_en_n++;
            end
            next_cycle();
            if (a_if_n != 0) a_if_req = 1'b0;
            if (a_dm_n != 0) a_dm_req = 1'b0;
            if (b_if_n != 0) b_if_req = 1'b0;
            if (b_dm_n != 0) b_dm_req = 1'b0;
        end
        a_if_req = 1'b0; a_dm_req = 1'b0; b_if_req = 1'b0; b_dm_req = 1'b0;
        chk({tag, " a_if_ack_cycle"}, a_if_c, v.a_if_cyc);
        chk({tag, " a_dm_ack_cycle"}, a_dm_c, v.a_dm_cyc);
        chk({tag, " b_if_ack_cycle"}, b_if_c, v.b_if_cyc);
        chk({tag, " b_dm_ack_cycle"}, b_dm_c, v.b_dm_cyc);
        chk({tag, " a_ack_pulses"}, a_if_n + a_dm_n, v.n_grant);
        chk({tag, " b_ack_pulses"}, b_if_n + b_dm_n, v.n_grant);
        chk({tag, " a_mem_en_cycles"}, a_en_n, v.n_grant);
        chk({tag, " b_mem_en_cycles"}, b_en_n, v.n_grant);
        chk({tag, " a_first_en_cycle"}, a_en_c0, 1);
        chk({tag, " b_first_en_cycle"}, b_en_c0, 1);
        chk({tag, " a_mem_adr0"}, a_adr[0], v.adr0);
        chk({tag, " b_mem_adr0"}, b_adr[0], v.adr0);
        chk({tag, " a_mem_we0"}, a_we0, v.we0);
        chk({tag, " b_mem_we0"}, b_we0, v.we0);
        if (v.we0) chk({tag, " a_mem_wdata0"}, a_wd0, v.dm_wdata);
        if (v.n_grant > 1) begin
            chk({tag, " a_mem_adr1"}, a_adr[1], v.adr1);
            chk({tag, " b_mem_adr1"}, b_adr[1], v.adr1);
        end
        chk({tag, " a_if_rdata"}, a_if_rdata, v.exp_if_rdata);
        chk({tag, " a_dm_rdata"}, a_dm_rdata, v.exp_dm_rdata);
        chk({tag, " b_if_rdata"}, b_if_rdata, v.exp_if_rdata);
        chk({tag, " b_dm_rdata"}, b_dm_rdata, v.exp_dm_rdata);
    endtask

    initial begin
        vec_t  vecs[4];
        vec_t  post;
        string exp_order;
        string a_order;
        string b_order;

        vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4, -1, 3, -1,
                    32'h2010_0005, 32'h0, 1, 32'h40, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, -1, 4, -1, 3,
                    32'h2010_0005, 32'h0, 1, 32'h100, 1'b1, 32'h0};
        vecs[2] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h200, 32'h0, 9, 4, 7, 3,
                    32'h00A0_0093, 32'h1234_5678, 2, 32'h200, 1'b0, 32'h44};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, -1, 4, -1, 3,
                    32'h00A0_0093, 32'h2010_0005, 1, 32'h40, 1'b0, 32'h0};
        post    = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 4, -1, 3, -1,
                    32'h00A0_0093, 32'h0, 1, 32'h44, 1'b0, 32'h0};

        sample_point();
        chk_all_zero("reset");
        next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();

        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            repeat (2) next_cycle();
        end

        // Starvation cap: both requesters held continuously.
        exp_order = "DDDDIDDDDI";
        a_order = "";
        b_order = "";
        if_adr = 32'h40; dm_adr = 32'h200; dm_we = 1'b0;
        a_if_req = 1'b1; a_dm_req = 1'b1; b_if_req = 1'b1; b_dm_req = 1'b1;
        for (int c = 0; c < 80 && (a_order.len() < 10 || b_order.len() < 10); c++) begin
            sample_point();
            if (a_order.len() < 10 && a_if_ack) a_order = {a_order, "I"};
            if (a_order.len() < 10 && a_dm_ack) a_order = {a_order, "D"};
            if (b_order.len() < 10 && b_if_ack) b_order = {b_order, "I"};
            if (b_order.len() < 10 && b_dm_ack) b_order = {b_order, "D"};
            next_cycle();
        end
        a_if_req = 1'b0; a_dm_req = 1'b0; b_if_req = 1'b0; b_dm_req = 1'b0;
        chk("starve a_grant_count", a_order.len(), 10);
        chk("starve b_grant_count", b_order.len(), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("starve a_grant%0d", i + 1),
                (i < a_order.len()) ? 32'(a_order[i]) : 32'd0, 32'(exp_order[i]));
            chk($sformatf("starve b_grant%0d", i + 1),
                (i < b_order.len()) ? 32'(b_order[i]) : 32'd0, 32'(exp_order[i]));
        end
        repeat (8) next_cycle();

        // Reset arriving while a read is in its WAIT phase.
        if_adr = 32'h44;
        a_if_req = 1'b1; b_if_req = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        a_if_req = 1'b0; b_if_req = 1'b0;
        next_cycle();
        sample_point();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            sample_point();
            chk($sformatf("mid_rst no_ack%0d", c),
                {28'd0, a_if_ack, a_dm_ack, b_if_ack, b_dm_ack}, 32'd0);
        end
        next_cycle();
        run_vec("post_rst", post);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
